vxe_vpu_cmd_dispatch: RTL

Upstream stage of the VPU register update ECU. Pops commands from the VPU command FIFO (fed by the control unit), decodes the opcode and issues a one-cycle dispatch pulse with latched op/thread/payload to either the register update ECU or the vector product ECU. It then waits for that ECU's done pulse, or a timeout, before popping the next command. Commands are strictly serialized, one in flight per VPU.

---
 rtl/vxe_vpu_cmd_dispatch.sv | 97 +++++++++
 1 files changed

// File: rtl/vxe_vpu_cmd_dispatch.sv
// vxe_vpu_cmd_dispatch: pops VPU commands, dispatches them to the register update or vector product ECU, waits for done or timeout
module vxe_vpu_cmd_dispatch #(
  parameter int TMO_CYCLES = 1024,
  parameter int TMO_W = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vld,
  input  logic [55:0] i_rdata,
  output logic        o_rd,
  output logic [4:0]  o_cmd_op,
  output logic [2:0]  o_cmd_th,
  output logic [47:0] o_cmd_pl,
  output logic        o_regu_disp,
  input  logic        i_regu_done,
  output logic        o_prod_disp,
  input  logic        i_prod_done,
  output logic        o_busy,
  output logic        o_err,
  output logic        o_err_tmo,
  input  logic        i_err_clr
);
  localparam logic [4:0] CU_CMD_NOP = 5'd0;
  localparam logic [4:0] CU_CMD_SETACC = 5'd1;
  localparam logic [4:0] CU_CMD_SETVL = 5'd2;
  localparam logic [4:0] CU_CMD_SETEN = 5'd3;
  localparam logic [4:0] CU_CMD_SETRS = 5'd4;
  localparam logic [4:0] CU_CMD_SETRT = 5'd5;
  localparam logic [4:0] CU_CMD_SETRD = 5'd6;
  localparam logic [4:0] CU_CMD_PROD = 5'd7;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES == 0 ? 0 : TMO_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DISP, WAIT} state_t;
  state_t state, state_n;
  logic [TMO_W-1:0] cnt;
  logic [4:0] op;
  logic pop, is_regu, is_prod, cmd_prod, done, err_set, tmo_set;
  assign op = i_rdata[55:51];
  assign is_regu = op inside {CU_CMD_SETACC, CU_CMD_SETVL, CU_CMD_SETEN, CU_CMD_SETRS, CU_CMD_SETRT, CU_CMD_SETRD};
  assign is_prod = op == CU_CMD_PROD;
  assign cmd_prod = o_cmd_op == CU_CMD_PROD;
  assign done = cmd_prod ? i_prod_done : i_regu_done;
  // a pop is blocked while o_rd is high: the FIFO's empty flag lags the pop by a cycle
  always_comb begin
    state_n = state;
    pop = 1'b0;
    err_set = 1'b0;
    tmo_set = 1'b0;
    case (state)
      IDLE: begin
        pop = i_vld && !o_rd;
        state_n = pop && (is_regu || is_prod) ? DISP : IDLE;
        err_set = pop && !is_regu && !is_prod && op != CU_CMD_NOP;
      end
      DISP: state_n = WAIT;
      WAIT: begin
        tmo_set = !done && TMO_CYCLES != 0 && cnt == TMO_LAST;
        err_set = tmo_set;
        state_n = done || tmo_set ? IDLE : WAIT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      o_rd <= 1'b0;
      o_regu_disp <= 1'b0;
      o_prod_disp <= 1'b0;
      o_busy <= 1'b0;
      o_err <= 1'b0;
      o_err_tmo <= 1'b0;
      o_cmd_op <= '0;
      o_cmd_th <= '0;
      o_cmd_pl <= '0;
    end else begin
      state <= state_n;
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      o_rd <= pop;
      o_regu_disp <= state == DISP && !cmd_prod;
      o_prod_disp <= state == DISP && cmd_prod;
      o_busy <= state_n != IDLE;
      if (pop) begin
        o_cmd_op <= op;
        o_cmd_th <= i_rdata[50:48];
        o_cmd_pl <= i_rdata[47:0];
      end
      if (err_set) begin
        o_err <= 1'b1;
        o_err_tmo <= tmo_set;
      end else if (i_err_clr) begin
        o_err <= 1'b0;
        o_err_tmo <= 1'b0;
      end
    end
  end
endmodule
